// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared constants, state encoding and vector helper for int_ctrl
package int_pkg;

  localparam int NUM_SRC_DEF = 4;

  localparam int SRC_INT0 = 0;
  localparam int SRC_T0   = 1;
  localparam int SRC_INT1 = 2;
  localparam int SRC_T1   = 3;

  localparam int EX0_BIT = 0;
  localparam int ET0_BIT = 1;
  localparam int EX1_BIT = 2;
  localparam int ET1_BIT = 3;
  localparam int EA_BIT  = 7;

  localparam logic [15:0] VEC_BASE_DEF   = 16'h0003;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } int_state_e;

  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [15:0] stride,
                                           input logic [1:0]  sel);
    return base + stride * {14'd0, sel};
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - CPU-side request/acknowledge handshake of int_ctrl
interface int_ctrl_if;
  logic        ins_boundary;
  logic        irq_ack;
  logic        reti;
  logic        irq_req;
  logic [15:0] irq_vec;

  modport master (output ins_boundary, irq_ack, reti, input irq_req, irq_vec);
  modport slave  (input ins_boundary, irq_ack, reti, output irq_req, irq_vec);
endinterface

// File: rtl/int_sync_edge.sv
// rtl/int_sync_edge.sv - 2-FF synchronizer with falling-edge detect for one active-low pin
module int_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  // Idle-high reset so a pin held high at reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - 8051-style 4-source vectored interrupt controller; INT_CTRL_NEST_EN enables two-level nesting
module int_ctrl
  import int_pkg::*;
#(
  parameter int          NUM_SRC    = NUM_SRC_DEF,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         int_n_i,
  input  logic [1:0]         it_edge_i,
  input  logic [1:0]         timer_ovf_i,
  input  logic [7:0]         ie_i,
  input  logic [7:0]         ip_i,
  int_ctrl_if.slave          cpu,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [1:0]         in_service_o
);

  logic [1:0]         pin_sync, pin_fall;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [1:0]         in_service_q, in_service_d;
  logic [NUM_SRC-1:0] set_v, is_level, level_val, eligible, prio, hi_set, pick;
  logic [1:0]         sel_q, cand;
  logic               cand_valid, cand_hi, allowed, ack_fire, sel_lvl, unused_bits;
  logic [1:0]         act_rank, cand_rank;
  int_state_e         state_q;
  logic               irq_req_q;
  logic [15:0]        irq_vec_q;

  int_sync_edge u_sync0 (.clk(clk), .rst_n(rst_n), .d_i(int_n_i[0]), .sync_o(pin_sync[0]), .fall_o(pin_fall[0]));
  int_sync_edge u_sync1 (.clk(clk), .rst_n(rst_n), .d_i(int_n_i[1]), .sync_o(pin_sync[1]), .fall_o(pin_fall[1]));

`ifdef INT_CTRL_NEST_EN
  assign prio        = ip_i[NUM_SRC-1:0];
  assign unused_bits = ^{ie_i[6:4], ip_i[7:4]};
`else
  assign prio        = '0;
  assign unused_bits = ^{ie_i[6:4], ip_i};
`endif

  // Source order: [0]=INT0, [1]=T0, [2]=INT1, [3]=T1 (matches IE/IP bit order).
  assign set_v     = {timer_ovf_i[1], pin_fall[1] & it_edge_i[1], timer_ovf_i[0], pin_fall[0] & it_edge_i[0]};
  assign is_level  = {1'b0, ~it_edge_i[1], 1'b0, ~it_edge_i[0]};
  assign level_val = {1'b0, ~pin_sync[1], 1'b0, ~pin_sync[0]};
  assign eligible  = pending_q & ie_i[NUM_SRC-1:0] & {NUM_SRC{ie_i[EA_BIT]}};
  assign ack_fire  = (state_q == ST_REQ) && cpu.irq_ack;
  assign sel_lvl   = prio[sel_q];

  always_comb begin
    hi_set     = eligible & prio;
    pick       = (|hi_set) ? hi_set : eligible;
    cand_hi    = |hi_set;
    cand_valid = |eligible;
    cand       = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pick[i]) cand = 2'(i);
    end
    act_rank  = in_service_q[1] ? 2'd2 : (in_service_q[0] ? 2'd1 : 2'd0);
    cand_rank = cand_hi ? 2'd2 : 2'd1;
    allowed   = cand_valid && (cand_rank > act_rank);
  end

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (is_level[i])                       pending_d[i] = level_val[i];
      else if (set_v[i])                     pending_d[i] = 1'b1;
      else if (ack_fire && sel_q == 2'(i))   pending_d[i] = 1'b0;
    end
  end

  // RETI retires the top level before the same-cycle ack marks the new one.
  always_comb begin
    in_service_d = in_service_q;
    if (cpu.reti) begin
      if (in_service_q[1]) in_service_d[1] = 1'b0;
      else                 in_service_d[0] = 1'b0;
    end
    if (ack_fire) in_service_d[sel_lvl] = 1'b1;
`ifndef INT_CTRL_NEST_EN
    in_service_d[1] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      in_service_q <= 2'b00;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      irq_req_q <= 1'b0;
      irq_vec_q <= 16'h0000;
      sel_q     <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu.ins_boundary && allowed && !cpu.reti) begin
            state_q   <= ST_REQ;
            irq_req_q <= 1'b1;
            sel_q     <= cand;
            irq_vec_q <= vec_addr(VEC_BASE, VEC_STRIDE, cand);
          end
        end
        ST_REQ: begin
          if (cpu.irq_ack || !eligible[sel_q]) begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.irq_req  = irq_req_q;
  assign cpu.irq_vec  = irq_vec_q;
  assign pending_o    = pending_q;
  assign in_service_o = in_service_q;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- 8051-style interrupt controller. Schedules the four interrupt sources for the CPU core: INT0, T0, INT1, T1.
- Latches source flags, applies IE/IP enable and priority, and raises one vectored request at instruction boundaries.
- Tracks in-service levels for nesting and retires them on RETI.
- Sits beside the CPU core. Its source inputs correspond to the core's `interupt[1:0]` and `timer[1:0]` pins.

Parameters:
- NUM_SRC, 4, number of sources. Fixed polling order: 0=INT0, 1=T0, 2=INT1, 3=T1.
- VEC_BASE, 16'h0003, vector address of source 0.
- VEC_STRIDE, 8, vector spacing in bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- int_n  in  2  external interrupt pins, active-low, asynchronous. [0]=INT0, [1]=INT1.
- it_edge  in  2  per-pin trigger mode (IT0/IT1). 1 = falling edge, 0 = low level.
- timer_ovf  in  2  one-cycle overflow pulses, synchronous. [0]=T0, [1]=T1.
- ie  in  8  enable register. Bit 7 = EA, bit 3 = ET1, bit 2 = EX1, bit 1 = ET0, bit 0 = EX0.
- ip  in  8  priority register, same bit layout as ie. 1 = high priority.
- ins_boundary  in  1  one-cycle pulse when the CPU enters instruction fetch.
- irq_ack  in  1  one-cycle pulse: CPU has saved PC and is jumping to irq_vec.
- reti  in  1  one-cycle pulse: CPU executed RETI.
- irq_req  out  1  interrupt request to CPU.
- irq_vec  out  16  vector address. Valid while irq_req = 1.
- pending  out  4  latched source flags (IE0, TF0, IE1, TF1).
- in_service  out  2  active levels. [0] = low, [1] = high.

Behaviour:
- Reset (rst_n, asynchronous, active-low; clock clk): irq_req=0, irq_vec=16'h0000, pending=0, in_service=0, FSM=IDLE, synchronizer flops=1.
- Synchronization: int_n passes through a 2-FF synchronizer. Edge detect registers the synchronized value; a falling edge is sync_prev=1 and sync=0.
- Latency: pin falling edge to pending bit set is 3 clk.
- Edge mode pending: the bit is set on a falling edge and cleared on irq_ack for that source.
  - Set and clear in the same cycle: set wins.
- Level mode pending: the bit equals the inverted synchronized pin (live). irq_ack does not clear it.
- Timer pending: the bit is set on a timer_ovf pulse and cleared on irq_ack for that source. Set wins over a same-cycle clear.
- Eligibility: eligible[i] = pending[i] & enable bit[i] & EA.
- Selection:
  - Candidate = highest-priority eligible source.
  - Among sources at the same priority, the lowest index wins.
  - A candidate is allowed only if its level is above the highest active in_service level. With nothing in service the level is -1.
- FSM states:
  - IDLE:
    - If ins_boundary=1, an allowed candidate exists, and reti=0 this cycle: latch sel, irq_vec = VEC_BASE + sel*VEC_STRIDE, go to REQ.
    - irq_req rises the next cycle, so request latency is 1 clk after ins_boundary.
  - REQ:
    - Hold irq_req=1 with irq_vec and sel stable.
    - On irq_ack: clear pending[sel] (edge or timer sources only), set in_service[level of sel], drop irq_req, go to IDLE.
    - If the latched source becomes ineligible and irq_ack=0: drop irq_req and go to IDLE with no state change.
    - If ineligibility and irq_ack occur in the same cycle, irq_ack wins.
    - A new higher-priority source arriving in REQ does not replace sel.
- RETI: clears the highest set in_service bit. RETI with in_service=0 is ignored.
- Simultaneous irq_ack and reti: apply the reti clear first, then the ack set.
- irq_vec arithmetic: 16-bit, no wrap checking.
- ins_boundary outside IDLE is ignored.
- Reset mid-REQ: abandons the request immediately. The CPU sees irq_req=0 asynchronously.

Optional Feature:
- Macro: INT_CTRL_NEST_EN.
- Defined: two priority levels from ip, nesting as above, in_service holds 2 bits.
- Undefined:
  - ip is ignored and all sources are treated as low priority.
  - in_service[1] is tied to 0.
  - Any active in_service blocks all new requests. There is no preemption.

Decomposition:
- Package int_pkg:
  - Source index constants (SRC_INT0, SRC_T0, SRC_INT1, SRC_T1).
  - IE/IP bit positions, EA_BIT.
  - FSM state encoding (IDLE, REQ).
  - Default VEC_BASE and VEC_STRIDE.
- Sub-module int_sync_edge: 2-FF synchronizer plus falling-edge detector, one bit wide. Instantiated twice.

Test Plan:
- Edge trigger:
  - Stimulus: ie=8'h81, it_edge=2'b01. Pulse int_n[0] low for 2 clk. Pulse ins_boundary.
  - Response: pending=4'b0001 3 clk after the edge; irq_req=1 and irq_vec=16'h0003 one clk after ins_boundary; irq_ack clears pending and sets in_service=2'b01.
- Polling order:
  - Stimulus: ie=8'h8F, ip=0. timer_ovf[1] and timer_ovf[0] pulse in the same cycle. Pulse ins_boundary.
  - Response: irq_vec=16'h000B (T0). After ack, and RETI, the next boundary gives 16'h001B.
- Nesting (INT_CTRL_NEST_EN):
  - Stimulus: T0 serviced at low priority. ip=8'h08, then timer_ovf[1] pulses. Pulse ins_boundary.
  - Response: request with vec 16'h001B; after ack in_service=2'b11. First reti gives 2'b01, second gives 2'b00.
- Same-level block:
  - Stimulus: INT1 arrives while INT0 is in service at equal priority.
  - Response: no irq_req until reti. Request at the next boundary.
- Level mode:
  - Stimulus: it_edge=0, int_n[0] held low across ack.
  - Response: pending[0] stays 1. After reti, re-request at the next boundary. A request is never raised in the reti cycle.
- Withdrawal:
  - Stimulus: in REQ, clear EA with no ack.
  - Response: irq_req drops the next clk, pending unchanged, in_service unchanged.
